// File: rtl/uart_word_packer.sv
// Packs received UART bytes little-endian into memory words, writes them to
// sequential addresses up to a programmed end address, then checks an XOR checksum byte.
`timescale 1ns/1ps

module uart_word_packer #(
    parameter int WORD_WIDTH = 36,
    parameter int UART_WIDTH = 8,
    parameter int MEM_DEPTH  = 4096,
    localparam int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] end_addr,
    input  logic                  byte_valid,
    input  logic [UART_WIDTH-1:0] byte_in,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WORD_WIDTH-1:0] mem_data,
    output logic                  busy,
    output logic                  done,
    output logic                  chk_err,
    output logic [ADDR_WIDTH:0]   word_count
);

    localparam int BYTES_PER_WORD = (WORD_WIDTH + UART_WIDTH - 1) / UART_WIDTH;
    localparam int IDX_WIDTH      = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam int ASM_WIDTH      = BYTES_PER_WORD * UART_WIDTH;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        CHECK   = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] end_addr_q;
    logic [ADDR_WIDTH-1:0] addr;
    logic [IDX_WIDTH-1:0]  byte_idx;
    logic [UART_WIDTH-1:0] checksum;
    logic [ASM_WIDTH-1:0]  asm_q;
    logic [ASM_WIDTH-1:0]  asm_next;

    logic accept_start;
    logic take_byte;
    logic last_byte;
    logic last_word;
    logic check_byte;

    assign accept_start = start && !abort && (state == IDLE || state == DONE);
    assign take_byte    = byte_valid && !abort && (state == COLLECT);
    assign last_byte    = take_byte && (byte_idx == IDX_WIDTH'(BYTES_PER_WORD - 1));
    assign last_word    = last_byte && (addr == end_addr_q);
    assign check_byte   = byte_valid && !abort && (state == CHECK);

    assign busy = (state == COLLECT) || (state == CHECK);
    assign done = (state == DONE);

    // Slots above WORD_WIDTH are dropped when the word is written out.
    always_comb begin
        asm_next = asm_q;
        for (int k = 0; k < BYTES_PER_WORD; k++) begin
            if (byte_idx == IDX_WIDTH'(k)) begin
                asm_next[k*UART_WIDTH +: UART_WIDTH] = byte_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = COLLECT;
            COLLECT: if (last_word) state_next = CHECK;
            CHECK:   if (byte_valid) state_next = DONE;
            DONE:    if (start) state_next = COLLECT;
            default: state_next = IDLE;
        endcase
        if (abort) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            end_addr_q <= '0;
            addr       <= '0;
            byte_idx   <= '0;
            checksum   <= '0;
            asm_q      <= '0;
            mem_wr_en  <= 1'b0;
            mem_addr   <= '0;
            mem_data   <= '0;
            chk_err    <= 1'b0;
            word_count <= '0;
        end else if (abort) begin
            end_addr_q <= '0;
            addr       <= '0;
            byte_idx   <= '0;
            checksum   <= '0;
            asm_q      <= '0;
            mem_wr_en  <= 1'b0;
            mem_addr   <= '0;
            mem_data   <= '0;
            chk_err    <= 1'b0;
            word_count <= '0;
        end else begin
            mem_wr_en <= 1'b0;
            if (accept_start) begin
                end_addr_q <= end_addr;
                addr       <= '0;
                byte_idx   <= '0;
                checksum   <= '0;
                asm_q      <= '0;
                chk_err    <= 1'b0;
                word_count <= '0;
            end
            if (take_byte) begin
                checksum <= checksum ^ byte_in;
                asm_q    <= asm_next;
                if (last_byte) begin
                    mem_wr_en  <= 1'b1;
                    mem_addr   <= addr;
                    mem_data   <= asm_next[WORD_WIDTH-1:0];
                    word_count <= word_count + (ADDR_WIDTH+1)'(1);
                    byte_idx   <= '0;
                    // The final address is held so a full-depth transfer never wraps.
                    if (addr != end_addr_q) begin
                        addr <= addr + ADDR_WIDTH'(1);
                    end
                end else begin
                    byte_idx <= byte_idx + IDX_WIDTH'(1);
                end
            end
            if (check_byte) begin
                chk_err <= (byte_in != checksum);
            end
        end
    end

endmodule

// File: doc/uart_word_packer.md
Name: uart_word_packer

Overview:
- Receive-side stage between uart_system and data memory.
- Consumes the per-byte pulses from the UART receiver and packs consecutive bytes, little-endian, into WORD_WIDTH-bit memory words.
- Writes each completed word to sequential addresses starting at 0, up to a programmed end address.
- Then checks one trailing XOR checksum byte and reports done or error to the top-level state machine.

Parameters:
- WORD_WIDTH, 36: memory word width in bits (CORE_COUNT*REG_WIDTH).
- UART_WIDTH, 8: received byte width in bits.
- MEM_DEPTH, 4096: memory depth in words.
- ADDR_WIDTH, $clog2(MEM_DEPTH): address width. Derived; not overridden.
- BYTES_PER_WORD, ceil(WORD_WIDTH/UART_WIDTH) = 5: bytes per word. Derived.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rstN  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; arms reception.
- abort  in  1  synchronous cancel; returns to IDLE.
- end_addr  in  ADDR_WIDTH  last word address (inclusive); sampled when start is accepted.
- byte_valid  in  1  one-cycle pulse from uart_system: a new byte is present.
- byte_in  in  UART_WIDTH  received byte; valid when byte_valid=1.
- mem_wr_en  out  1  memory write strobe; one cycle per word.
- mem_addr  out  ADDR_WIDTH  write address.
- mem_data  out  WORD_WIDTH  assembled word.
- busy  out  1  high in COLLECT and CHECK.
- done  out  1  level; high in DONE.
- chk_err  out  1  level; valid while done=1.
- word_count  out  ADDR_WIDTH+1  number of words written since start.

Behaviour:
- Reset (async, rstN=0): state=IDLE. mem_wr_en=0, mem_addr=0, mem_data=0, busy=0, done=0, chk_err=0, word_count=0. Byte index and checksum register cleared.
- IDLE:
  - start=1 → COLLECT.
  - On entry to COLLECT: latch end_addr, clear byte index, checksum, address and word_count.
  - byte_valid is ignored.
- COLLECT:
  - Each byte_valid stores byte_in into byte slot k (bits [8k+7:8k], k=0 first) of the assembly register and XORs it into the checksum.
  - The top byte slot keeps only the low WORD_WIDTH-(BYTES_PER_WORD-1)*UART_WIDTH bits (4 for the defaults). The full byte still enters the checksum.
  - On the BYTES_PER_WORD-th byte: the next cycle drives mem_wr_en=1 for exactly 1 cycle, with mem_addr = current address and mem_data = assembled word. Latency is 1 clock from the last byte_valid to the write strobe.
  - After the write: address+1, word_count+1, byte index back to 0.
  - If the written address equals the latched end_addr → CHECK. Otherwise stay in COLLECT.
  - A byte_valid arriving in the same cycle as mem_wr_en is accepted into slot 0 of the next word; no byte is lost.
  - mem_addr/mem_data hold their last values when mem_wr_en=0.
- CHECK:
  - The next byte_valid compares byte_in with the checksum register. chk_err = (byte_in != checksum). Then → DONE.
- DONE:
  - done=1, busy=0, outputs held.
  - start=1 → re-arms exactly as from IDLE (done and chk_err clear on the same edge).
  - byte_valid is ignored.
- Boundary conditions:
  - start while busy: ignored.
  - abort in any state: → IDLE on the next edge. Outputs return to reset values. A write strobe pending in that cycle is suppressed.
  - abort and start in the same cycle: abort wins.
  - end_addr=0: one word, then the checksum byte.
  - end_addr=MEM_DEPTH-1: address reaches MEM_DEPTH-1 and never wraps; word_count reaches MEM_DEPTH (this is why it is ADDR_WIDTH+1 bits).
  - Reset mid-transfer: immediate return to reset values; partial word discarded.
- State encoding is a 2-bit enum: IDLE=0, COLLECT=1, CHECK=2, DONE=3. Illegal encodings → IDLE.

Test Plan:
- Reset with rstN low mid-COLLECT, after 3 bytes → all outputs 0, state IDLE. After release, start and bytes 11,22,33,44,05 write 0x544332211 to addr 0.
- start with end_addr=0, then bytes 11,22,33,44,05 → mem_wr_en high exactly 1 cycle after the 5th byte_valid, mem_addr=0, mem_data=0x544332211. Checksum byte 0x41 → done=1, chk_err=0, word_count=1.
- Same data with checksum byte 0x40 → done=1, chk_err=1. A following start pulse clears done and chk_err on the next edge.
- end_addr=2 with 15 bytes back-to-back at 1 byte/cycle → writes at addr 0,1,2 with no lost byte. Byte 0xF5 in the top slot stores 0x5 in bits [35:32] while 0xF5 enters the checksum.
- abort asserted on the same cycle as the last byte of word 1 → no write to addr 1, state IDLE, word_count=0. start during COLLECT → no effect.
- end_addr=4095 with streamed random words → the final write goes to addr 4095 with word_count=4096, no wrap to 0, then DONE after the checksum byte.
